// File: rtl/conv_row_writer_pkg.sv
// Shared constants and state encoding for the convolution row writer.
package conv_row_writer_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/conv_row_writer_if.sv
// Result stream from the binary-convolution datapath into the row writer.
interface conv_row_writer_if;
    logic result_valid;
    logic result_bit;
    logic row_last;
    logic frame_last;
    logic result_ready;

    modport master (
        output result_valid,
        output result_bit,
        output row_last,
        output frame_last,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_bit,
        input  row_last,
        input  frame_last,
        output result_ready
    );
endinterface

// File: rtl/conv_row_writer_bit_packer.sv
// Packs accepted result bits LSB-first into a word; word is the combinational
// view including the bit being accepted this cycle.
module conv_row_writer_bit_packer #(
    parameter int W = conv_row_writer_pkg::WORD_W
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         clear,
    input  logic         bit_in,
    input  logic         accept,
    input  logic         row_end,
    output logic [W-1:0] word,
    output logic         word_complete
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  acc;
    logic [CW-1:0] count;

    always_comb begin
        word = acc;
        if (accept)
            word[count] = bit_in;
    end

    assign word_complete = accept && ((count == CW'(W - 1)) || row_end);

    // A completed word is handed off, so the packer restarts empty immediately.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            acc   <= '0;
            count <= '0;
        end else if (clear || word_complete) begin
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= word;
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/conv_row_writer.sv
// Write-back stage: packs the 1-bit convolution stream into SRAM words at
// consecutive addresses from a programmable base, and reports busy/done.
module conv_row_writer #(
    parameter int WORD_W = conv_row_writer_pkg::WORD_W,
    parameter int ADDR_W = conv_row_writer_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    conv_row_writer_if.slave  res,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [WORD_W-1:0] sram_write_data,
    output logic              busy,
    output logic              done
);
    import conv_row_writer_pkg::*;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ACCUM = ACCUM;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              frame_start;
    logic [WORD_W-1:0] packed_word;
    logic              word_complete;

    assign res.result_ready = (state == S_ACCUM);
    assign accept           = res.result_valid && res.result_ready;
    assign frame_start      = (state == S_IDLE) && start;
    assign busy             = (state == S_ACCUM) || (state == S_FLUSH);
    assign done             = (state == S_DONE);

    conv_row_writer_bit_packer #(.W(WORD_W)) packer (
        .clk           (clk),
        .reset_b       (reset_b),
        .clear         (frame_start),
        .bit_in        (res.result_bit),
        .accept        (accept),
        .row_end       (res.row_last || res.frame_last),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_ACCUM;
                S_ACCUM: if (accept && res.frame_last) state <= S_FLUSH;
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data and address hold between writes; only the enable pulses.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            addr               <= '0;
            sram_write_enable  <= 1'b0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
        end else begin
            sram_write_enable <= word_complete;
            if (frame_start) begin
                addr <= base_addr;
            end else if (word_complete) begin
                sram_write_data    <= packed_word;
                sram_write_address <= addr;
                addr               <= addr + 1'b1;
            end
        end
    end
endmodule
